rle_encoder: RTL

- Run-length encoder stage directly downstream of the zigzag reorder stage.
- Consumes 8 zigzag-ordered quantized coefficients per input word, eight words per 8x8 block, and emits one (run, value) symbol per cycle toward the Huffman stage.
- Coefficient 0 of each block is emitted as a DC symbol; AC coefficients are run-length coded with ZRL (16 zeros) and EOB symbols per JPEG baseline.
- Valid/ready handshake on the output. Ready backpressure on the input.

---
 rtl/rle_encoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rle_encoder.sv
// JPEG-baseline run-length coder for zigzag-ordered 8x8 blocks.
// Takes eight coefficients per word and emits one (run, value) symbol per cycle.
module rle_encoder #(
    parameter int unsigned BW = 10
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_valid,
    output logic            o_in_ready,
    output logic            o_valid,
    input  logic            i_out_ready,
    output logic [3:0]      o_run,
    output logic [BW-1:0]   o_value,
    output logic            o_dc,
    output logic            o_eob
);

    typedef enum logic [1:0] {StIdle, StScan, StZrl, StEob} state_e;

    state_e        r_state;
    logic [BW-1:0] r_buf [8];
    logic          r_buf_full;
    logic [2:0]    r_idx;
    logic [2:0]    r_word_cnt;
    logic [5:0]    r_zcnt;

    logic          r_valid;
    logic [3:0]    r_run;
    logic [BW-1:0] r_value;
    logic          r_dc;
    logic          r_eob;

    logic          w_adv;
    logic [BW-1:0] w_coef;
    logic          w_nz;
    logic          w_pos0;
    logic          w_last_idx;
    logic          w_last_pos;
    logic          w_to_zrl;
    logic          w_consume;
    logic          w_in_ready;
    logic          w_load;
    logic          w_buf_full_d;

    always_comb begin
        w_adv        = ~r_valid | i_out_ready;
        w_coef       = r_buf[r_idx];
        w_nz         = |w_coef;
        w_last_idx   = (r_idx == 3'd7);
        w_pos0       = (r_word_cnt == 3'd0) && (r_idx == 3'd0);
        w_last_pos   = (r_word_cnt == 3'd7) && w_last_idx;
        // A nonzero behind 16+ zeros stays in the buffer until the ZRLs drain the count.
        w_to_zrl     = (r_state == StScan) && w_adv && !w_pos0 && w_nz && (r_zcnt >= 6'd16);
        w_consume    = (r_state == StScan) && w_adv && !w_to_zrl;
        w_in_ready   = ~r_buf_full | (w_last_idx & w_consume);
        w_load       = i_valid & w_in_ready;
        w_buf_full_d = w_load | (r_buf_full & ~(w_consume & w_last_idx));
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state    <= StIdle;
            for (int k = 0; k < 8; k++) begin
                r_buf[k] <= '0;
            end
            r_buf_full <= 1'b0;
            r_idx      <= 3'd0;
            r_word_cnt <= 3'd0;
            r_zcnt     <= 6'd0;
            r_valid    <= 1'b0;
            r_run      <= 4'd0;
            r_value    <= '0;
            r_dc       <= 1'b0;
            r_eob      <= 1'b0;
        end else begin
            if (w_load) begin
                for (int k = 0; k < 8; k++) begin
                    r_buf[k] <= i_data[(7-k)*BW +: BW];
                end
                r_idx <= 3'd0;
            end else if (w_consume) begin
                r_idx <= r_idx + 3'd1;
            end
            r_buf_full <= w_buf_full_d;

            if (w_consume && w_last_idx) begin
                r_word_cnt <= r_word_cnt + 3'd1;
            end

            // An accepted symbol drops unless a new one is emitted below.
            if (r_valid && i_out_ready) begin
                r_valid <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_load) begin
                        r_state <= StScan;
                    end
                end

                StScan: begin
                    if (w_to_zrl) begin
                        r_state <= StZrl;
                    end else if (w_consume) begin
                        if (w_pos0) begin
                            r_valid <= 1'b1;
                            r_run   <= 4'd0;
                            r_value <= w_coef;
                            r_dc    <= 1'b1;
                            r_eob   <= 1'b0;
                            r_zcnt  <= 6'd0;
                        end else if (!w_nz) begin
                            r_zcnt  <= r_zcnt + 6'd1;
                        end else begin
                            r_valid <= 1'b1;
                            r_run   <= r_zcnt[3:0];
                            r_value <= w_coef;
                            r_dc    <= 1'b0;
                            r_eob   <= 1'b0;
                            r_zcnt  <= 6'd0;
                        end

                        if (w_last_pos && !w_nz) begin
                            r_state <= StEob;
                        end else if (w_last_idx && !w_load) begin
                            r_state <= StIdle;
                        end
                    end
                end

                StZrl: begin
                    if (w_adv) begin
                        r_valid <= 1'b1;
                        r_run   <= 4'd15;
                        r_value <= '0;
                        r_dc    <= 1'b0;
                        r_eob   <= 1'b0;
                        r_zcnt  <= r_zcnt - 6'd16;
                        if (r_zcnt < 6'd32) begin
                            r_state <= StScan;
                        end
                    end
                end

                StEob: begin
                    if (w_adv) begin
                        r_valid <= 1'b1;
                        r_run   <= 4'd0;
                        r_value <= '0;
                        r_dc    <= 1'b0;
                        r_eob   <= 1'b1;
                        r_zcnt  <= 6'd0;
                        r_state <= w_buf_full_d ? StScan : StIdle;
                    end
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_valid    = r_valid;
    assign o_run      = r_run;
    assign o_value    = r_value;
    assign o_dc       = r_dc;
    assign o_eob      = r_eob;

endmodule
